chess_turn_ctrl: RTL

- Turn sequencer for the chess clock. It drives the enable, set, min and per-player stop inputs of the two-player countdown datapath.
- Button presses select whose clock runs. The controller detects flag fall from the countdown time outputs and holds a full-move counter.
- Sits between the board-level button inputs and the countdown pair. Outputs go to the display and buzzer logic.

---
 rtl/chess_turn_ctrl_pkg.sv | 33 +++
 rtl/chess_turn_ctrl_btn_sync_edge.sv | 30 +++
 rtl/chess_turn_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/chess_turn_ctrl_pkg.sv
// Shared state encoding and per-state stop/preset output table for the chess
// clock turn sequencer.
package chess_turn_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        RUN1  = 3'd1,
        RUN2  = 3'd2,
        PAUSE = 3'd3,
        FLAG  = 3'd4
    } state_e;

    typedef struct packed {
        logic sw0;
        logic sw1;
        logic set;
    } ctrl_t;

    // Only the running player's clock is released; presets load only in IDLE.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        case (s)
            IDLE:    c = '{sw0: 1'b1, sw1: 1'b1, set: 1'b1};
            RUN1:    c = '{sw0: 1'b0, sw1: 1'b1, set: 1'b0};
            RUN2:    c = '{sw0: 1'b1, sw1: 1'b0, set: 1'b0};
            default: c = '{sw0: 1'b1, sw1: 1'b1, set: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/chess_turn_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button pin followed by a
// rising-edge detector that yields a single-cycle pulse per press.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: non-blocking assignments let all three flops sample together, forming a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Combinational pulse so the consuming register acts on the 3rd edge.
    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/chess_turn_ctrl.sv
// Turn sequencer for a two-player chess clock: button-driven state machine,
// flag-fall detection, full-move counter and buzzer timer.
module chess_turn_ctrl
    import chess_turn_ctrl_pkg::*;
#(
    parameter int TW          = 5,
    parameter int MOVE_W      = 8,
    parameter int BUZZ_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_p1,
    input  logic              btn_p2,
    input  logic              btn_start,
    input  logic              btn_pause,
    input  logic              btn_new,
    input  logic              btn_min,
    input  logic [TW-1:0]     min1,
    input  logic [TW-1:0]     seg1,
    input  logic [TW-1:0]     min2,
    input  logic [TW-1:0]     seg2,
    output logic              enable,
    output logic              set,
    output logic              min,
    output logic              sw0,
    output logic              sw1,
    output logic [2:0]        state,
    output logic              flag1,
    output logic              flag2,
    output logic [MOVE_W-1:0] moves,
    output logic              buzzer
);

    localparam int BUZZ_W = $clog2(BUZZ_CYCLES + 1);
    localparam logic [BUZZ_W-1:0] BUZZ_MAX = BUZZ_W'(BUZZ_CYCLES);

    logic p1_p, p2_p, start_p, pause_p, new_p, min_p;

    btn_sync_edge u_sync_p1    (.clk(clk), .rst_n(rst_n), .btn(btn_p1),    .pulse(p1_p));
    btn_sync_edge u_sync_p2    (.clk(clk), .rst_n(rst_n), .btn(btn_p2),    .pulse(p2_p));
    btn_sync_edge u_sync_start (.clk(clk), .rst_n(rst_n), .btn(btn_start), .pulse(start_p));
    btn_sync_edge u_sync_pause (.clk(clk), .rst_n(rst_n), .btn(btn_pause), .pulse(pause_p));
    btn_sync_edge u_sync_new   (.clk(clk), .rst_n(rst_n), .btn(btn_new),   .pulse(new_p));
    btn_sync_edge u_sync_min   (.clk(clk), .rst_n(rst_n), .btn(btn_min),   .pulse(min_p));

    logic zero1, zero2;
    assign zero1 = (min1 == '0) && (seg1 == '0);
    assign zero2 = (min2 == '0) && (seg2 == '0);

    state_e              state_q, state_d, resume_q, resume_d;
    logic                flag1_q, flag1_d, flag2_q, flag2_d;
    logic                min_q, min_d, buzzer_q, buzzer_d, enable_q;
    logic [MOVE_W-1:0]   moves_q, moves_d;
    logic [BUZZ_W-1:0]   buzz_cnt_q, buzz_cnt_d;
    ctrl_t               ctrl_q, ctrl_d;

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        flag1_d    = flag1_q;
        flag2_d    = flag2_q;
        moves_d    = moves_q;
        buzz_cnt_d = buzz_cnt_q;
        buzzer_d   = buzzer_q;
        min_d      = 1'b0;

        case (state_q)
            IDLE: begin
                min_d = min_p;
                if (start_p) state_d = RUN1;
            end
            RUN1: begin
                if (zero1) begin
                    state_d = FLAG;
                    flag1_d = 1'b1;
                end else if (new_p) begin
                    state_d = IDLE;
                end else if (pause_p) begin
                    state_d  = PAUSE;
                    resume_d = RUN1;
                end else if (p1_p) begin
                    state_d = RUN2;
                end
            end
            RUN2: begin
                if (zero2) begin
                    state_d = FLAG;
                    flag2_d = 1'b1;
                end else if (new_p) begin
                    state_d = IDLE;
                end else if (pause_p) begin
                    state_d  = PAUSE;
                    resume_d = RUN2;
                end else if (p2_p) begin
                    state_d = RUN1;
                    moves_d = moves_q + 1'b1;
                end
            end
            PAUSE: begin
                if (new_p)                   state_d = IDLE;
                else if (pause_p || start_p) state_d = resume_q;
            end
            FLAG: begin
                // Counter saturates at BUZZ_MAX; buzzer stays high until it gets there.
                buzzer_d = (buzz_cnt_q < BUZZ_MAX);
                if (buzz_cnt_q < BUZZ_MAX) buzz_cnt_d = buzz_cnt_q + 1'b1;
                if (new_p) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == FLAG && state_q != FLAG) begin
            buzzer_d   = 1'b1;
            buzz_cnt_d = BUZZ_W'(1);
        end

        if (state_d == IDLE) begin
            flag1_d    = 1'b0;
            flag2_d    = 1'b0;
            moves_d    = '0;
            buzzer_d   = 1'b0;
            buzz_cnt_d = '0;
        end

        ctrl_d = state_ctrl(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            resume_q   <= RUN1;
            enable_q   <= 1'b0;
            ctrl_q     <= '{sw0: 1'b1, sw1: 1'b1, set: 1'b1};
            min_q      <= 1'b0;
            flag1_q    <= 1'b0;
            flag2_q    <= 1'b0;
            moves_q    <= '0;
            buzz_cnt_q <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            enable_q   <= 1'b1;
            ctrl_q     <= ctrl_d;
            min_q      <= min_d;
            flag1_q    <= flag1_d;
            flag2_q    <= flag2_d;
            moves_q    <= moves_d;
            buzz_cnt_q <= buzz_cnt_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign enable = enable_q;
    assign set    = ctrl_q.set;
    assign sw0    = ctrl_q.sw0;
    assign sw1    = ctrl_q.sw1;
    assign min    = min_q;
    assign state  = state_q;
    assign flag1  = flag1_q;
    assign flag2  = flag2_q;
    assign moves  = moves_q;
    assign buzzer = buzzer_q;

endmodule
